dram_ctrl: RTL and testbench
============================

Name: dram_ctrl

Overview:
- Responder-side DRAM controller for the main RAM array.
- Accepts cycles that the bus controller has already decoded: ramCEn low for the life of a CPU cycle, then negated when cpuASn rises.
- Drives multiplexed row/column address, RASn, per-byte CASn and WEn to a 32-bit FPM SIMM, and returns ramACKn, which the bus controller converts into cpuSTERMn.
- Generates CAS-before-RAS refresh autonomously.

Parameters:
- ROW_BITS, 11, width of the multiplexed DRAM address bus.
- RAS_CAS, 1, clocks from RAS fall to column address/CAS fall (min 1).
- CAS_WIDTH, 2, clocks CAS held low before ack (min 1).
- PRECHARGE, 2, clocks RAS/CAS held high after any access or refresh (min 1).
- REFRESH_PERIOD, 390, clocks between refresh requests (15.6 us at 25 MHz).
- REFRESH_WIDTH, 3, clocks RAS held low during refresh.

Ports:
- sysClk, input, 1: system clock; all logic on rising edge.
- sysRESETn, input, 1: asynchronous active-low reset.
- ramCEn, input, 1: RAM select from bus controller; active low.
- cpuRWn, input, 1: 1 = read, 0 = write.
- cpuSIZ, input, 2: 68030 transfer size.
- cpuAddr, input, 2*ROW_BITS: CPU A[2*ROW_BITS+1:2]; column = low ROW_BITS, row = high ROW_BITS.
- cpuAddrLo, input, 2: CPU A[1:0].
- dramAddr, output, ROW_BITS: multiplexed row/column address.
- dramRASn, output, 1: row strobe.
- dramCASn, output, 4: column strobes. [3] = D31:24, [0] = D7:0.
- dramWEn, output, 1: write enable.
- ramACKn, output, 1: cycle acknowledge; active low.
- refBusy, output, 1: high while a refresh sequence is in progress (debug/verification).

Behaviour:
- Reset (async, sysRESETn low):
  - dramRASn = 1, dramCASn = 4'hF, dramWEn = 1, ramACKn = 1, dramAddr = 0, refBusy = 0.
  - State = IDLE, refresh counter = REFRESH_PERIOD-1, refresh pending = 0.
  - Reset asserted mid-cycle releases all strobes immediately; no precharge is guaranteed.
- Refresh timer:
  - Free-running down-counter. At 0 it reloads to REFRESH_PERIOD-1 and sets refresh pending.
  - Pending clears on entry to REF1.
  - A second expiry while still pending is absorbed (one pending refresh maximum).
- States:
  - IDLE:
    - Refresh pending has priority over ramCEn low sampled in the same clock → REF1.
    - Otherwise ramCEn low → ROW: dramAddr = row, dramRASn = 0, dramWEn = cpuRWn.
  - ROW: hold RAS_CAS clocks, then → COL: dramAddr = column, dramCASn = lane mask.
    - Read lane mask = 4'b0000.
    - Write lane mask = active-low of byte enables, from cpuSIZ (S1,S0) and A[1:0]:
      - UUD = ~A1&~A0
      - UMD = ~A1&A0 | ~A1&~S0 | ~A1&S1
      - LMD = A1&~A0 | ~A1&~S0&~S1 | ~A1&S1&S0 | ~A1&A0&~S0
      - LLD = A1&A0 | A0&S0&S1 | ~S0&~S1 | A1&S1
  - COL: hold CAS_WIDTH clocks, then → ACK with ramACKn = 0.
  - ACK:
    - ramACKn stays low until ramCEn samples high.
    - On ramCEn high: ramACKn = 1, RAS = 1, CAS = F, WEn = 1 → PRE.
  - PRE: hold PRECHARGE clocks with all strobes high → IDLE.
  - REF1: refBusy = 1, dramCASn = 4'h0, WEn = 1 → REF2 next clock.
  - REF2: dramRASn = 0; hold REFRESH_WIDTH clocks → REF3.
  - REF3: RAS = 1, CAS = F → PRE. refBusy clears on PRE exit.
- Abort: if ramCEn goes high in ROW or COL (CPU abandoned the cycle, e.g. BERR), release all strobes, do not assert ramACKn → PRE.
- ramCEn low during REF*/PRE: the request waits and is serviced from IDLE.
  - Worst-case latency (defaults) must stay well below the bus controller's 255-clock timeout.
- Latency with defaults, IDLE ramCEn sample to ramACKn low: 1 + RAS_CAS + CAS_WIDTH = 4 clocks.
- ramACKn never asserts during refresh. dramWEn only asserts with dramRASn low.

Test Plan:
- Reset: assert sysRESETn low mid-COL → all strobes high and ramACKn = 1 within the same cycle, state IDLE after release.
- Longword read, addr 0x001234, SIZ = 00, A = 00:
  - Row 0x000 then column 0x48D on dramAddr.
  - CAS = 0000, WEn = 1.
  - ramACKn low 4 clocks after ramCEn; ramACKn held until ramCEn high, then PRE for 2 clocks.
- Byte write SIZ = 01 at A = 10 → CAS = 1101, WEn = 0. Word write SIZ = 10 at A = 01 → CAS = 1001.
- Refresh collision: timer expires on the same clock ramCEn falls:
  - CBR sequence first (CAS low one clock before RAS, RAS low 3 clocks).
  - Then the access; ramACKn asserted only after refBusy = 0.
- Abort: ramCEn rises during COL → no ramACKn pulse, strobes high next clock, PRE then IDLE.
- Refresh spacing: idle 2000 clocks → exactly 5 refresh sequences at 390-clock intervals.

Source files
------------

// File: rtl/dram_ctrl.sv
// rtl/dram_ctrl.sv - FPM DRAM controller with CAS-before-RAS refresh
//
// Responder-side controller for a 32-bit FPM SIMM. A decoded CPU cycle
// (ramCEn low) is turned into a RAS/CAS sequence and then acknowledged with
// ramACKn. Refresh is generated internally and takes priority over new cycles.
//
// Ports:
//   sysClk, sysRESETn        clock, asynchronous active-low reset
//   ramCEn, cpuRWn, cpuSIZ   decoded RAM select, direction, 68030 size
//   cpuAddr, cpuAddrLo       CPU A[2*ROW_BITS+1:2] (row = high half), A[1:0]
//   dramAddr, dramRASn,      multiplexed address and strobes to the SIMM
//   dramCASn, dramWEn        (dramCASn[3] = D31:24)
//   ramACKn                  cycle acknowledge back to the bus controller
//   refBusy                  high while a refresh sequence is in progress
module dram_ctrl #(
  parameter int ROW_BITS       = 11,
  parameter int RAS_CAS        = 1,
  parameter int CAS_WIDTH      = 2,
  parameter int PRECHARGE      = 2,
  parameter int REFRESH_PERIOD = 390,
  parameter int REFRESH_WIDTH  = 3
) (
  input  logic                  sysClk,
  input  logic                  sysRESETn,
  input  logic                  ramCEn,
  input  logic                  cpuRWn,
  input  logic [1:0]            cpuSIZ,
  input  logic [2*ROW_BITS-1:0] cpuAddr,
  input  logic [1:0]            cpuAddrLo,
  output logic [ROW_BITS-1:0]   dramAddr,
  output logic                  dramRASn,
  output logic [3:0]            dramCASn,
  output logic                  dramWEn,
  output logic                  ramACKn,
  output logic                  refBusy
);

  localparam int REF_W = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REFRESH_PERIOD - 1);
  localparam logic [7:0] RAS_CAS_LD = 8'(RAS_CAS - 1);
  localparam logic [7:0] CAS_W_LD   = 8'(CAS_WIDTH - 1);
  localparam logic [7:0] PRE_LD     = 8'(PRECHARGE - 1);
  localparam logic [7:0] REF_W_LD   = 8'(REFRESH_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, ROW, COL, ACK, PRE, REF1, REF2, REF3
  } state_t;

  state_t             state;
  logic [7:0]         holdCnt;
  logic [REF_W-1:0]   refCnt;
  logic               refPend;
  logic               refExpire;
  logic               refNow;
  logic [3:0]         laneEn;
  logic               s1, s0, a1, a0;

  assign s1 = cpuSIZ[1];
  assign s0 = cpuSIZ[0];
  assign a1 = cpuAddrLo[1];
  assign a0 = cpuAddrLo[0];

  // 68030 byte-lane enables for writes; [3] is the upper byte (D31:24).
  assign laneEn[3] = ~a1 & ~a0;
  assign laneEn[2] = (~a1 & a0) | (~a1 & ~s0) | (~a1 & s1);
  assign laneEn[1] = (a1 & ~a0) | (~a1 & ~s0 & ~s1) | (~a1 & s1 & s0) | (~a1 & a0 & ~s0);
  assign laneEn[0] = (a1 & a0) | (a0 & s0 & s1) | (~s0 & ~s1) | (a1 & s1);

  // An expiry in the same clock as an IDLE request still wins, so a refresh
  // colliding with a falling ramCEn is served first.
  assign refExpire = (refCnt == '0);
  assign refNow    = refPend | refExpire;

  always_ff @(posedge sysClk or negedge sysRESETn) begin
    if (!sysRESETn) begin
      state    <= IDLE;
      holdCnt  <= '0;
      refCnt   <= REF_RELOAD;
      refPend  <= 1'b0;
      dramAddr <= '0;
      dramRASn <= 1'b1;
      dramCASn <= 4'hF;
      dramWEn  <= 1'b1;
      ramACKn  <= 1'b1;
      refBusy  <= 1'b0;
    end else begin
      refCnt <= refExpire ? REF_RELOAD : refCnt - 1'b1;

      // Entering REF1 consumes the pending request (including one expiring now);
      // a further expiry while pending is simply absorbed.
      if (state == IDLE && refNow) begin
        refPend <= 1'b0;
      end else if (refExpire) begin
        refPend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (refNow) begin
            state    <= REF1;
            refBusy  <= 1'b1;
            dramCASn <= 4'h0;
            dramWEn  <= 1'b1;
          end else if (!ramCEn) begin
            state    <= ROW;
            holdCnt  <= RAS_CAS_LD;
            dramAddr <= cpuAddr[2*ROW_BITS-1:ROW_BITS];
            dramRASn <= 1'b0;
            dramWEn  <= cpuRWn;
          end
        end
        ROW: begin
          if (ramCEn) begin
            // CPU abandoned the cycle: drop everything, no acknowledge.
            state    <= PRE;
            holdCnt  <= PRE_LD;
            dramRASn <= 1'b1;
            dramCASn <= 4'hF;
            dramWEn  <= 1'b1;
          end else if (holdCnt == '0) begin
            state    <= COL;
            holdCnt  <= CAS_W_LD;
            dramAddr <= cpuAddr[ROW_BITS-1:0];
            dramCASn <= cpuRWn ? 4'h0 : ~laneEn;
          end else begin
            holdCnt <= holdCnt - 1'b1;
          end
        end
        COL: begin
          if (ramCEn) begin
            state    <= PRE;
            holdCnt  <= PRE_LD;
            dramRASn <= 1'b1;
            dramCASn <= 4'hF;
            dramWEn  <= 1'b1;
          end else if (holdCnt == '0) begin
            state   <= ACK;
            ramACKn <= 1'b0;
          end else begin
            holdCnt <= holdCnt - 1'b1;
          end
        end
        ACK: begin
          if (ramCEn) begin
            state    <= PRE;
            holdCnt  <= PRE_LD;
            ramACKn  <= 1'b1;
            dramRASn <= 1'b1;
            dramCASn <= 4'hF;
            dramWEn  <= 1'b1;
          end
        end
        PRE: begin
          if (holdCnt == '0) begin
            state   <= IDLE;
            refBusy <= 1'b0;
          end else begin
            holdCnt <= holdCnt - 1'b1;
          end
        end
        REF1: begin
          // CAS has been low for one clock; now drop RAS for the CBR cycle.
          state    <= REF2;
          holdCnt  <= REF_W_LD;
          dramRASn <= 1'b0;
        end
        REF2: begin
          if (holdCnt == '0) begin
            state    <= REF3;
            dramRASn <= 1'b1;
            dramCASn <= 4'hF;
          end else begin
            holdCnt <= holdCnt - 1'b1;
          end
        end
        REF3: begin
          state   <= PRE;
          holdCnt <= PRE_LD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// tb/tb_dram_ctrl.sv - self-checking bench for dram_ctrl
module tb_dram_ctrl;

  localparam int ROW_BITS       = 11;
  localparam int RAS_CAS        = 1;
  localparam int CAS_WIDTH      = 2;
  localparam int PRECHARGE      = 2;
  localparam int REFRESH_PERIOD = 390;
  localparam int REFRESH_WIDTH  = 3;
  localparam int ACK_LAT        = 1 + RAS_CAS + CAS_WIDTH;
  localparam int TW             = ROW_BITS + 7;

  logic                  sysClk = 1'b0;
  logic                  sysRESETn = 1'b1;
  logic                  ramCEn = 1'b1;
  logic                  cpuRWn = 1'b1;
  logic [1:0]            cpuSIZ = 2'b00;
  logic [2*ROW_BITS-1:0] cpuAddr = '0;
  logic [1:0]            cpuAddrLo = 2'b00;
  logic [ROW_BITS-1:0]   dramAddr;
  logic                  dramRASn;
  logic [3:0]            dramCASn;
  logic                  dramWEn;
  logic                  ramACKn;
  logic                  refBusy;

  int checks = 0;
  int failures = 0;
  int wenViol = 0;
  int ackViol = 0;

  dram_ctrl #(
    .ROW_BITS(ROW_BITS), .RAS_CAS(RAS_CAS), .CAS_WIDTH(CAS_WIDTH),
    .PRECHARGE(PRECHARGE), .REFRESH_PERIOD(REFRESH_PERIOD),
    .REFRESH_WIDTH(REFRESH_WIDTH)
  ) dut (
    .sysClk(sysClk), .sysRESETn(sysRESETn), .ramCEn(ramCEn), .cpuRWn(cpuRWn),
    .cpuSIZ(cpuSIZ), .cpuAddr(cpuAddr), .cpuAddrLo(cpuAddrLo),
    .dramAddr(dramAddr), .dramRASn(dramRASn), .dramCASn(dramCASn),
    .dramWEn(dramWEn), .ramACKn(ramACKn), .refBusy(refBusy)
  );

  always #5 sysClk = ~sysClk;

  always @(negedge sysClk) begin
    if (sysRESETn === 1'b1) begin
      if (dramWEn === 1'b0 && dramRASn !== 1'b0) wenViol++;
      if (ramACKn === 1'b0 && refBusy !== 1'b0) ackViol++;
    end
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic doReset();
    sysRESETn = 1'b0;
    ramCEn    = 1'b1;
    tick();
    sysRESETn = 1'b1;
  endtask

  // Active-low CAS mask from which bytes the transfer actually covers.
  function automatic logic [3:0] expCas(input logic rwn, input logic [1:0] siz,
                                        input logic [1:0] lo);
    logic [3:0] en;
    int n;
    en = 4'b0000;
    n = (siz == 2'd0) ? 4 : int'(siz);
    if (rwn) return 4'h0;
    for (int b = int'(lo); b < 4 && b < int'(lo) + n; b++) en[3-b] = 1'b1;
    return ~en;
  endfunction

  // Full access: checks row/column phases, ack latency and hold, release and precharge.
  task automatic access(input logic [2*ROW_BITS-1:0] a, input logic [1:0] siz,
                        input logic [1:0] lo, input logic rwn, input int hold,
                        input string nm);
    logic [ROW_BITS-1:0] rowE, colE;
    logic [3:0] casE;
    logic [TW-1:0] got, exp;
    rowE = ROW_BITS'(a >> ROW_BITS);
    colE = ROW_BITS'(a);
    casE = expCas(rwn, siz, lo);
    cpuAddr = a; cpuSIZ = siz; cpuAddrLo = lo; cpuRWn = rwn; ramCEn = 1'b0;
    for (int c = 0; c < RAS_CAS; c++) begin
      tick();
      got = {dramRASn, dramCASn, dramWEn, ramACKn, dramAddr};
      exp = {1'b0, 4'hF, rwn, 1'b1, rowE};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL %s_row c%0d: got %h expected %h", nm, c, got, exp); end
    end
    for (int c = 0; c < CAS_WIDTH; c++) begin
      tick();
      got = {dramRASn, dramCASn, dramWEn, ramACKn, dramAddr};
      exp = {1'b0, casE, rwn, 1'b1, colE};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL %s_col c%0d: got %h expected %h", nm, c, got, exp); end
    end
    for (int c = 0; c <= hold; c++) begin
      tick();
      got = {dramRASn, dramCASn, dramWEn, ramACKn, dramAddr};
      exp = {1'b0, casE, rwn, 1'b0, colE};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL %s_ack c%0d: got %h expected %h", nm, c, got, exp); end
    end
    ramCEn = 1'b1;
    tick();
    checks++;
    if ({dramRASn, dramCASn, dramWEn, ramACKn} !== 7'h7F) begin
      failures++; $display("FAIL %s_release: got %h expected 7f", nm, {dramRASn, dramCASn, dramWEn, ramACKn});
    end
    for (int c = 0; c < PRECHARGE; c++) begin
      tick();
      checks++;
      if ({dramRASn, dramCASn, dramWEn, ramACKn} !== 7'h7F) begin
        failures++; $display("FAIL %s_pre c%0d: got %h expected 7f", nm, c, {dramRASn, dramCASn, dramWEn, ramACKn});
      end
    end
  endtask

  task automatic test_reset();
    sysRESETn = 1'b1;
    #2 sysRESETn = 1'b0;
    #2;
    checks++;
    if ({dramRASn, dramCASn, dramWEn, ramACKn, refBusy, dramAddr} !== {8'hFE, {ROW_BITS{1'b0}}}) begin
      failures++; $display("FAIL reset_values: got %h expected %h",
        {dramRASn, dramCASn, dramWEn, ramACKn, refBusy, dramAddr}, {8'hFE, {ROW_BITS{1'b0}}});
    end
    tick();
    sysRESETn = 1'b1;
    cpuAddr = 22'h0ABCDE; cpuRWn = 1'b1; ramCEn = 1'b0;
    tick();
    tick();
    checks++;
    if ({dramRASn, dramCASn} !== 5'h00) begin
      failures++; $display("FAIL reset_pre_col: got %h expected 00", {dramRASn, dramCASn});
    end
    #3 sysRESETn = 1'b0;
    #1;
    checks++;
    if ({dramRASn, dramCASn, dramWEn, ramACKn} !== 7'h7F) begin
      failures++; $display("FAIL reset_midcol: got %h expected 7f", {dramRASn, dramCASn, dramWEn, ramACKn});
    end
    ramCEn = 1'b1;
    tick();
    sysRESETn = 1'b1;
    tick();
    checks++;
    if ({dramRASn, dramCASn, dramWEn, ramACKn, refBusy} !== 8'hFE) begin
      failures++; $display("FAIL reset_idle: got %h expected fe", {dramRASn, dramCASn, dramWEn, ramACKn, refBusy});
    end
    access(22'h155555, 2'b00, 2'b00, 1'b1, 0, "post_reset");
  endtask

  task automatic test_directed();
    doReset();
    access(22'(24'h001234 >> 2), 2'b00, 2'b00, 1'b1, 2, "lw_read");
    access(22'h3A5F0C, 2'b01, 2'b10, 1'b0, 1, "byte_write");
    access(22'h012345, 2'b10, 2'b01, 1'b0, 0, "word_write");
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 20; i++) begin
      access(22'($urandom), 2'($urandom_range(3)), 2'($urandom_range(3)),
             1'($urandom_range(1)), $urandom_range(3), $sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_abort_back_to_back();
    int firstRas, firstAck;
    doReset();
    cpuAddr = 22'($urandom); cpuRWn = 1'b0; cpuSIZ = 2'b00; cpuAddrLo = 2'b00;
    ramCEn = 1'b0;
    for (int c = 0; c < RAS_CAS + 1; c++) tick();
    ramCEn = 1'b1;
    tick();
    checks++;
    if ({dramRASn, dramCASn, dramWEn, ramACKn} !== 7'h7F) begin
      failures++; $display("FAIL abort_release: got %h expected 7f", {dramRASn, dramCASn, dramWEn, ramACKn});
    end
    ramCEn = 1'b0;
    firstRas = -1; firstAck = -1;
    for (int e = 1; e <= 30 && firstAck < 0; e++) begin
      tick();
      if (dramRASn === 1'b0 && firstRas < 0) firstRas = e;
      if (ramACKn === 1'b0) firstAck = e;
    end
    checks++;
    if (firstRas !== PRECHARGE + 1) begin
      failures++; $display("FAIL abort_pre_len: got %0d expected %0d", firstRas, PRECHARGE + 1);
    end
    checks++;
    if (firstAck !== PRECHARGE + ACK_LAT) begin
      failures++; $display("FAIL abort_next_ack: got %0d expected %0d", firstAck, PRECHARGE + ACK_LAT);
    end
    ramCEn = 1'b1;
    repeat (PRECHARGE + 1) tick();
  endtask

  task automatic test_collision();
    int refFirst, casFirst, rasFirst, rasRef, refEnd, ackFirst;
    doReset();
    repeat (REFRESH_PERIOD - 1) tick();
    cpuAddr = 22'($urandom); cpuRWn = 1'b1; ramCEn = 1'b0;
    refFirst = -1; casFirst = -1; rasFirst = -1; rasRef = 0; refEnd = -1; ackFirst = -1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (refBusy === 1'b1 && refFirst < 0) refFirst = e;
      if (dramCASn !== 4'hF && casFirst < 0) casFirst = e;
      if (dramRASn === 1'b0 && rasFirst < 0) rasFirst = e;
      if (dramRASn === 1'b0 && refBusy === 1'b1) rasRef++;
      if (refFirst > 0 && refBusy === 1'b0 && refEnd < 0) refEnd = e;
      if (ramACKn === 1'b0 && ackFirst < 0) ackFirst = e;
    end
    checks++;
    if (refFirst !== 1) begin failures++; $display("FAIL coll_ref_first: got %0d expected 1", refFirst); end
    checks++;
    if (casFirst !== 1 || rasFirst !== 2) begin
      failures++; $display("FAIL coll_cbr_order: got cas %0d ras %0d expected cas 1 ras 2", casFirst, rasFirst);
    end
    checks++;
    if (rasRef !== REFRESH_WIDTH) begin
      failures++; $display("FAIL coll_ras_width: got %0d expected %0d", rasRef, REFRESH_WIDTH);
    end
    checks++;
    if (refEnd !== 3 + REFRESH_WIDTH + PRECHARGE) begin
      failures++; $display("FAIL coll_ref_end: got %0d expected %0d", refEnd, 3 + REFRESH_WIDTH + PRECHARGE);
    end
    checks++;
    if (ackFirst !== 3 + REFRESH_WIDTH + PRECHARGE + ACK_LAT) begin
      failures++; $display("FAIL coll_ack: got %0d expected %0d", ackFirst, 3 + REFRESH_WIDTH + PRECHARGE + ACK_LAT);
    end
    ramCEn = 1'b1;
    repeat (PRECHARGE + 1) tick();
  endtask

  task automatic test_refresh_spacing();
    int rises[$];
    logic prev;
    doReset();
    prev = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      tick();
      if (refBusy === 1'b1 && prev !== 1'b1) rises.push_back(n);
      prev = refBusy;
    end
    checks++;
    if (rises.size() !== 5) begin
      failures++; $display("FAIL refresh_count: got %0d expected 5", rises.size());
    end
    for (int i = 0; i < rises.size(); i++) begin
      checks++;
      if (rises[i] !== (i + 1) * REFRESH_PERIOD) begin
        failures++; $display("FAIL refresh_time%0d: got %0d expected %0d", i, rises[i], (i + 1) * REFRESH_PERIOD);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (wenViol !== 0) begin failures++; $display("FAIL wen_without_ras: got %0d expected 0", wenViol); end
    checks++;
    if (ackViol !== 0) begin failures++; $display("FAIL ack_during_refresh: got %0d expected 0", ackViol); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort_back_to_back();
    test_collision();
    test_refresh_spacing();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
